alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle.sv | 178 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with a start/done handshake and registered outputs.
// Defining ALU_MULDIV_EN adds the iterative MULTU/DIVU datapath and the HI register.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_LUI   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    // Single-cycle result; DIVU only lands here when b is zero.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LUI: alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = $signed(a) >>> shamt;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MULDIV_EN
            OP_DIVU: alu_res = '1;
`endif
            default: ;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [0:0]   S_IDLE   = 1'b0;
    localparam logic [0:0]   S_RUN    = 1'b1;
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [0:0]       state;
    logic [SHW:0]     count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             long_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    assign long_op = (alu_op == OP_MULTU) || ((alu_op == OP_DIVU) && (b != '0));
    assign busy    = (state == S_RUN);

    // acc_hi:acc_lo is the product (multiplier shifting out of acc_lo) or remainder:quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            nxt_hi = div_trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} : div_trial[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b1;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start && long_op) begin
                    state  <= S_RUN;
                    count  <= CNT_INIT;
                    is_div <= (alu_op == OP_DIVU);
                    acc_hi <= '0;
                    acc_lo <= (alu_op == OP_DIVU) ? a : b;
                    opnd   <= (alu_op == OP_DIVU) ? b : a;
                end else if (start) begin
                    result      <= alu_res;
                    zero        <= (alu_res == '0);
                    overflow    <= alu_ovf;
                    div_by_zero <= (alu_op == OP_DIVU);
                    done        <= 1'b1;
                    if (alu_op == OP_DIVU) begin
                        hi <= a;
                    end
                end
            end else begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                count  <= count - CNT_ONE;
                if (count == CNT_ONE) begin
                    state       <= S_IDLE;
                    result      <= nxt_lo;
                    hi          <= nxt_hi;
                    zero        <= (nxt_lo == '0);
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
            end
        end
    end
`else
    assign hi          = '0;
    assign busy        = 1'b0;
    assign div_by_zero = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                result   <= alu_res;
                zero     <= (alu_res == '0);
                overflow <= alu_ovf;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32); expectations follow
// ALU_MULDIV_EN so the same bench covers both builds.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   shamt;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         overflow;
    logic         div_by_zero;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
        .a(a), .b(b), .shamt(shamt), .result(result), .hi(hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [4:0] sh);
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        a      = av;
        b      = bv;
        shamt  = sh;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; alu_op = 4'd0; a = '0; b = '0; shamt = '0;
        repeat (2) step();
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_result: got %h want %h", result, 32'h0); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_hi: got %h want %h", hi, 32'h0); end
        n_cmp++; if ({zero, overflow, div_by_zero, busy, done} !== 5'b10000) begin
            n_bad++; $display("[TB] FAIL rst_flags: got %b want %b", {zero, overflow, div_by_zero, busy, done}, 5'b10000); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_overflow;
        drive(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        step();
        start = 1'b0;
        n_cmp++; if (result !== 32'h8000_0000) begin n_bad++; $display("[TB] FAIL add_result: got %h want %h", result, 32'h8000_0000); end
        n_cmp++; if ({overflow, zero, done} !== 3'b101) begin
            n_bad++; $display("[TB] FAIL add_flags: got %b want %b", {overflow, zero, done}, 3'b101); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL add_done_fall: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        drive(4'd4, 32'd5, 32'd5, 5'd0);
        step();
        n_cmp++; if ({result, zero, done} !== {32'h0, 2'b11}) begin
            n_bad++; $display("[TB] FAIL b2b_sub: got %h z%b d%b want 0 z1 d1", result, zero, done); end
        drive(4'd8, 32'h8000_0000, 32'h0, 5'd4);
        step();
        start = 1'b0;
        n_cmp++; if ({result, zero, done} !== {32'hF800_0000, 2'b01}) begin
            n_bad++; $display("[TB] FAIL b2b_sra: got %h z%b d%b want f8000000 z0 d1", result, zero, done); end
    endtask

    task automatic test_single_ops;
        logic [3:0]   ops [9]  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd9, 4'd4, 4'd13};
        logic [W-1:0] as  [9]  = '{32'hFF00_FF00, 32'hF000_0000, 32'h0F0F_0000, 32'h0, 32'h1,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234};
        logic [W-1:0] bs  [9]  = '{32'h0FF0_0FF0, 32'h0000_000F, 32'h0000_F0F0, 32'h1234_ABCD, 32'h0,
                                   32'h0, 32'h2, 32'h1, 32'h5678};
        logic [4:0]   shs [9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0, 5'd0, 5'd0};
        logic [W-1:0] exp [9]  = '{32'h0F00_0F00, 32'hF000_000F, 32'hF0F0_0F0F, 32'hABCD_0000, 32'h8000_0000,
                                   32'h0800_0000, 32'h1, 32'h7FFF_FFFF, 32'h0};
        logic         eovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(ops[i], as[i], bs[i], shs[i]);
            step();
            n_cmp++; if ({result, overflow, zero, done} !== {exp[i], eovf[i], (exp[i] == 32'h0), 1'b1}) begin
                n_bad++; $display("[TB] FAIL op%0d: got %h ovf%b z%b d%b want %h ovf%b", ops[i], result, overflow, zero, done, exp[i], eovf[i]); end
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_multu;
        int lat = 0;
        drive(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        step();
        start = 1'b0;
        if (MD) begin
            n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("[TB] FAIL mul_busy: got b%b d%b want b1 d0", busy, done); end
            for (int i = 1; i <= 40; i++) begin
                step();
                if (done) begin lat = i; break; end
            end
            n_cmp++; if (lat !== 32) begin n_bad++; $display("[TB] FAIL mul_latency: got %0d want 32", lat); end
            n_cmp++; if ({hi, result, busy} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
                n_bad++; $display("[TB] FAIL mul_value: got %h_%h b%b want fffffffe_00000001 b0", hi, result, busy); end
        end else begin
            n_cmp++; if ({hi, result, busy, done} !== {64'h0, 2'b01}) begin
                n_bad++; $display("[TB] FAIL mul_disabled: got %h_%h b%b d%b want 0_0 b0 d1", hi, result, busy, done); end
        end
        drive(4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        step();
        start = 1'b0;
        n_cmp++; if ({hi, result} !== {(MD ? 32'hFFFF_FFFE : 32'h0), 32'h0F0F_0000}) begin
            n_bad++; $display("[TB] FAIL hi_hold: got %h_%h want %h_0f0f0000", hi, result, MD ? 32'hFFFF_FFFE : 32'h0); end
    endtask

    task automatic test_divu;
        int lat = 0;
        drive(4'd11, 32'd100, 32'd7, 5'd0);
        step();
        start = 1'b0;
        if (MD) begin
            for (int i = 1; i <= 40; i++) begin
                if (i == 10) begin start = 1'b1; alu_op = 4'd3; a = 32'd1; b = 32'd1; end
                if (i == 11) start = 1'b0;
                step();
                if (done) begin lat = i; break; end
            end
            n_cmp++; if (lat !== 32) begin n_bad++; $display("[TB] FAIL div_latency: got %0d want 32", lat); end
            n_cmp++; if ({result, hi, zero, div_by_zero} !== {32'd14, 32'd2, 2'b00}) begin
                n_bad++; $display("[TB] FAIL div_value: got q%0d r%0d z%b dz%b want q14 r2", result, hi, zero, div_by_zero); end
        end else begin
            n_cmp++; if ({result, hi, done} !== {64'h0, 1'b1}) begin
                n_bad++; $display("[TB] FAIL div_disabled: got %h %h d%b want 0 0 d1", result, hi, done); end
        end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL div_done_fall: got %b want 0", done); end
    endtask

    task automatic test_div_by_zero;
        drive(4'd11, 32'h1234, 32'h0, 5'd0);
        step();
        start = 1'b0;
        n_cmp++; if ({result, hi, div_by_zero, busy, done} !== (MD ? {32'hFFFF_FFFF, 32'h1234, 3'b101} : {64'h0, 3'b001})) begin
            n_bad++; $display("[TB] FAIL divzero: got %h %h dz%b b%b d%b", result, hi, div_by_zero, busy, done); end
    endtask

    task automatic test_reset_abort;
        bit saw_done = 1'b0;
        drive(4'd10, 32'd3, 32'd5, 5'd0);
        step();
        start = 1'b0;
        repeat (10) step();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({result, hi, zero, overflow, div_by_zero, busy, done} !== {64'h0, 5'b10000}) begin
            n_bad++; $display("[TB] FAIL abort_state: got %h %h flags %b want 0 0 10000", result, hi,
                              {zero, overflow, div_by_zero, busy, done}); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_no_done: got %b want 0", saw_done); end
        drive(4'd3, 32'd2, 32'd3, 5'd0);
        step();
        start = 1'b0;
        n_cmp++; if ({result, done} !== {32'd5, 1'b1}) begin
            n_bad++; $display("[TB] FAIL abort_add: got %0d d%b want 5 d1", result, done); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_single_ops();
        test_multu();
        test_divu();
        test_div_by_zero();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
